// File: rtl/div32.sv
// ---------------------------------------------------------------------------
// div32 -- iterative 32-bit divider for MIPS DIV / DIVU
//
// Purpose:
//   Computes quotient (LO) and remainder (HI) with one restoring-division
//   step per clock. Latency is fixed and does not depend on the operands:
//   done is high in the cycle that begins 33 rising edges after the accept
//   edge.
//
// Ports:
//   clock       in   single clock, rising-edge active
//   reset_n     in   synchronous active-low reset
//   start       in   division request, honoured only when idle
//   is_signed   in   1 = DIV (signed), 0 = DIVU; sampled with start
//   dividend    in   [31:0] numerator (rs); sampled with start
//   divisor     in   [31:0] denominator (rt); sampled with start
//   busy        out  high from the accept edge until done rises
//   done        out  one-cycle pulse when the results are valid
//   quotient    out  [31:0] LO result, held until the next done or reset
//   remainder   out  [31:0] HI result, held until the next done or reset
//   div_by_zero out  sampled divisor was zero; valid with done
// ---------------------------------------------------------------------------
module div32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] rem_q, rem_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quo_out_q, quo_out_d;
  logic [31:0] rem_out_q, rem_out_d;
  logic        dbz_q, dbz_d;

  logic [32:0] shifted;
  logic [32:0] diff;

  // Next-state and datapath logic.
  // The operand signs are captured already masked by is_signed, so unsigned
  // operations simply see both signs as zero and no separate mode flop is
  // needed. dvd_q doubles as the quotient shift register: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;

    shifted = {rem_q, dvd_q[31]};
    diff    = shifted - {1'b0, dsr_q};

    case (state_q)
      IDLE: begin
        // done_q still high means this is the done cycle; a start seen here
        // belongs to the next cycle, so it is not accepted yet.
        if (start && !done_q) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = 6'd0;
          sign_a_d = is_signed & dividend[31];
          sign_b_d = is_signed & divisor[31];
          dvd_d    = (is_signed & dividend[31]) ? -dividend : dividend;
          dsr_d    = (is_signed & divisor[31])  ? -divisor  : divisor;
          rem_d    = 32'd0;
        end
      end

      RUN: begin
        // With a zero divisor both branches keep shifted[31:0], so after 32
        // steps rem_q holds the dividend magnitude, which FINISH re-signs
        // into the raw dividend.
        if (!diff[32]) begin
          rem_d = diff[31:0];
        end else begin
          rem_d = shifted[31:0];
        end
        dvd_d = {dvd_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        dbz_d     = (dsr_q == 32'd0);
        rem_out_d = sign_a_q ? -rem_q : rem_q;
        if (dsr_q == 32'd0) begin
          quo_out_d = 32'hFFFF_FFFF;
        end else begin
          // 0x80000000 / -1 wraps back to 0x80000000 here, as required.
          quo_out_d = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset wins over any request on the same edge and
  // abandons an operation in flight without a done pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      dvd_q     <= 32'd0;
      dsr_q     <= 32'd0;
      rem_q     <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= 32'd0;
      rem_out_q <= 32'd0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32.sv
// ---------------------------------------------------------------------------
// tb_div32 -- self-checking bench for div32
//
// A cycle-level behavioural model predicts busy/done timing and computes the
// results with plain integer division; a compare process checks every output
// on every falling edge. Directed cases with hand-computed literals pin the
// model, then a long randomized phase mixes requests, mid-operation input
// changes and occasional resets.
// ---------------------------------------------------------------------------
module tb_div32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int testsRun = 0;
  int testsFailed = 0;
  logic checkEn = 1'b0;

  div32 dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // 10 time-unit clock period.
  always #5 clock = ~clock;

  // Reference result packed as {div_by_zero, quotient, remainder}, derived
  // from the arithmetic rules alone: native integer division truncates
  // toward zero and the remainder follows the dividend's sign.
  function automatic logic [64:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'd0};
      sa = a;
      sb = b;
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Operand picker biased toward the interesting corners.
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Behavioural timing model: an accepted request completes 33 edges later;
  // requests are ignored while busy or while done is showing.
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mQ = 32'd0;
  logic [31:0] mR = 32'd0;
  logic        mZ = 1'b0;
  int          mCount = 0;
  logic [64:0] mPend = 65'd0;

  always @(posedge clock) begin
    if (!reset_n) begin
      mBusy  <= 1'b0;
      mDone  <= 1'b0;
      mQ     <= 32'd0;
      mR     <= 32'd0;
      mZ     <= 1'b0;
      mCount <= 0;
    end else if (mBusy) begin
      mDone <= 1'b0;
      if (mCount == 32) begin
        mBusy <= 1'b0;
        mDone <= 1'b1;
        {mZ, mQ, mR} <= mPend;
      end else begin
        mCount <= mCount + 1;
      end
    end else begin
      mDone <= 1'b0;
      if (start && !mDone) begin
        mBusy  <= 1'b1;
        mCount <= 0;
        mPend  <= refDiv(is_signed, dividend, divisor);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("quotient", quotient, mQ);
      checkOutput("remainder", remainder, mR);
      checkOutput("div_by_zero", 32'(div_by_zero), 32'(mZ));
    end
  end

  // Issue one request, scramble inputs after the accept edge, and wait
  // (bounded) for done. Optionally pulses a competing 9 / 3 request at
  // cycle intrudeAt after the accept edge. Returns with done high.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input int intrudeAt, output int lat);
    @(posedge clock); #1;
    start = 1'b1;
    is_signed = s;
    dividend = a;
    divisor = b;
    @(posedge clock); #1;
    start = 1'b0;
    is_signed = 1'($urandom);
    dividend = $urandom;
    divisor = $urandom;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == intrudeAt) begin
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd9;
        divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'd33);
  endtask

  initial begin
    int lat;
    logic sawDone;

    reset_n = 1'b0;
    @(posedge clock); #1;
    checkEn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_q", quotient, 32'd0);
    checkOutput("reset_r", remainder, 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    reset_n = 1'b1;

    applyStimulus(1'b0, 32'd100, 32'd7, 0, lat);
    checkOutput("u100div7_q", quotient, 32'd14);
    checkOutput("u100div7_r", remainder, 32'd2);
    checkOutput("u100div7_dbz", 32'(div_by_zero), 32'd0);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat);
    checkOutput("sneg7div2_q", quotient, 32'hFFFF_FFFD);
    checkOutput("sneg7div2_r", remainder, 32'hFFFF_FFFF);

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0, lat);
    checkOutput("umaxdiv1_q", quotient, 32'hFFFF_FFFF);
    checkOutput("umaxdiv1_r", remainder, 32'd0);

    applyStimulus(1'b0, 32'd5, 32'd0, 0, lat);
    checkOutput("u5div0_q", quotient, 32'hFFFF_FFFF);
    checkOutput("u5div0_r", remainder, 32'd5);
    checkOutput("u5div0_dbz", 32'(div_by_zero), 32'd1);

    applyStimulus(1'b1, 32'd5, 32'd0, 0, lat);
    checkOutput("s5div0_q", quotient, 32'hFFFF_FFFF);
    checkOutput("s5div0_r", remainder, 32'd5);
    checkOutput("s5div0_dbz", 32'(div_by_zero), 32'd1);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd0, 0, lat);
    checkOutput("sneg7div0_r", remainder, 32'hFFFF_FFF9);

    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
    checkOutput("ovf_q", quotient, 32'h8000_0000);
    checkOutput("ovf_r", remainder, 32'd0);
    checkOutput("ovf_dbz", 32'(div_by_zero), 32'd0);

    // Competing request mid-operation must be dropped entirely.
    applyStimulus(1'b0, 32'd100, 32'd7, 10, lat);
    checkOutput("intrude_q", quotient, 32'd14);
    checkOutput("intrude_r", remainder, 32'd2);

    // A start during the done cycle is ignored as well.
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd9;
    divisor = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    checkOutput("start_on_done_busy", 32'(busy), 32'd0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("no_extra_done", 32'(sawDone), 32'd0);

    // Reset in the middle of an operation, coinciding with a start request.
    @(posedge clock); #1;
    start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset_n = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    start = 1'b0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_q", quotient, 32'd0);
    checkOutput("midreset_r", remainder, 32'd0);
    checkOutput("midreset_dbz", 32'(div_by_zero), 32'd0);
    sawDone = 1'b0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("aborted_no_done", 32'(sawDone), 32'd0);

    applyStimulus(1'b0, 32'd9, 32'd3, 0, lat);
    checkOutput("u9div3_q", quotient, 32'd3);
    checkOutput("u9div3_r", remainder, 32'd0);

    // Randomized traffic: requests at any time, inputs changing every cycle,
    // and rare resets; the compare process checks everything.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      start = ($urandom_range(0, 3) == 0);
      is_signed = 1'($urandom);
      dividend = pick();
      divisor = pick();
      reset_n = ($urandom_range(0, 299) != 0);
    end
    @(posedge clock); #1;
    start = 1'b0;
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    checkEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/div32.md
DIV32 -- requirements
Module: div32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clock SHALL be an input, 1 bit wide, and is the single clock; all state updates occur on its rising edge.
REQ-003 Port reset_n SHALL be an input, 1 bit wide, and is the synchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide; it requests a division and is honoured only in IDLE.
REQ-005 Port is_signed SHALL be an input, 1 bit wide; 1 selects MIPS DIV, 0 selects DIVU; it is sampled with start.
REQ-006 Port dividend SHALL be an input, 32 bits wide, and is the numerator (rs); it is sampled with start.
REQ-007 Port divisor SHALL be an input, 32 bits wide, and is the denominator (rt); it is sampled with start.
REQ-008 Port busy SHALL be an output, 1 bit wide, high from the accept edge until done is asserted.
REQ-009 Port done SHALL be an output, 1 bit wide, high for exactly one cycle when the results are valid.
REQ-010 Port quotient SHALL be an output, 32 bits wide, carrying the LO value.
REQ-011 Port remainder SHALL be an output, 32 bits wide, carrying the HI value.
REQ-012 Port div_by_zero SHALL be an output, 1 bit wide, set when the sampled divisor was 0; it is valid with done.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-014 In IDLE with start=1, the block SHALL capture is_signed, the operand magnitudes and both operand signs, clear the 6-bit iteration counter, enter RUN and raise busy on that same edge (the accept edge).
REQ-015 In RUN, the block SHALL perform one restoring-division step per cycle: shift the partial remainder left 1 bit, inserting the next dividend MSB; subtract the divisor magnitude in 33-bit arithmetic; if the result is non-negative, keep it and shift in quotient bit 1, otherwise shift in 0.
REQ-016 After exactly 32 RUN steps, the FSM SHALL enter FINISH.
REQ-017 In FINISH, the block SHALL register the final quotient, remainder and div_by_zero values, pulse done, drop busy and return to IDLE.
REQ-018 done SHALL be high in exactly one cycle, the cycle beginning 33 rising edges after the accept edge.
REQ-019 Latency SHALL be independent of the operand values.
REQ-020 For signed operations, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend (truncating division).
REQ-021 All arithmetic SHALL be modulo 2^32; signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0, and no flag.
REQ-022 A divisor of 0 SHALL use the same latency, set div_by_zero=1, and return quotient 0xFFFFFFFF and remainder equal to the sampled raw dividend, in both signed and unsigned modes.
REQ-023 start SHALL be ignored while busy=1 or in FINISH; the operation in flight SHALL NOT be disturbed.
REQ-024 start asserted in the same cycle as done SHALL be ignored; a new request is accepted only from the next cycle.
REQ-025 quotient, remainder and div_by_zero SHALL hold their values from one done pulse until the next done pulse or reset.
REQ-026 Input changes after the accept edge SHALL NOT affect the result.

Reset
REQ-027 When reset_n=0 at a rising edge, the FSM SHALL enter IDLE, and busy, done, div_by_zero, quotient and remainder SHALL all be 0.
REQ-028 Reset asserted mid-operation SHALL abort the division, with no done pulse issued for the aborted operation.
REQ-029 Reset SHALL take priority over start on the same edge.

Verification
REQ-030 Unsigned: 100 / 7 -> quotient 14, remainder 2, div_by_zero 0; done exactly 33 edges after accept; busy high through those cycles.
REQ-031 Signed: 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-032 Divide by zero: 5 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, same latency.
REQ-033 Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
REQ-034 Start-while-busy: launch 100 / 7, then pulse start with 9 / 3 at cycle 10 -> a single done with 14 r2; the second request is never executed.
REQ-035 Reset mid-op: assert reset_n=0 at cycle 15 of a division -> next cycle all outputs 0 and IDLE; a fresh 9 / 3 then returns 3 r0 with normal latency.
